// File: rtl/spi_transaction_fsm.sv
// ---------------------------------------------------------------------------
// spi_transaction_fsm
//
// Control FSM for the SPI memory peripheral. One chip-select-low frame is a
// width-bit header {addr[width-2:0], rw} sent MSB first, followed by width data
// bits. rw=1 is a read and rw=0 is a write. The FSM uses the one-clk SCLK edge
// pulses from the input conditioner and the shift register's parallel output.
// It drives the address latch, the data memory write enable, the shift-register
// parallel load and the MISO tri-state enable.
//
// Ports
//   clk          in   1      system clock
//   resetN       in   1      asynchronous active-low reset
//   csN          in   1      synchronized chip select, active low
//   sclkPosEdge  in   1      1-clk pulse on SCLK rising edge
//   sclkNegEdge  in   1      1-clk pulse on SCLK falling edge
//   shiftRegOut  in   width  shift register parallel data out
//   addrWE       out  1      address latch enable, 1-clk pulse
//   dmWE         out  1      data memory write enable, 1-clk pulse
//   parallelLoad out  1      shift register parallel load
//   misoBufE     out  1      MISO tri-state buffer enable
// ---------------------------------------------------------------------------
module spi_transaction_fsm #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             csN,
    input  logic             sclkPosEdge,
    input  logic             sclkNegEdge,
    input  logic [width-1:0] shiftRegOut,
    output logic             addrWE,
    output logic             dmWE,
    output logic             parallelLoad,
    output logic             misoBufE
);

    typedef enum logic [2:0] {
        IDLE,
        GET_HDR,
        GOT_HDR,
        READ_LOAD,
        READ_SHIFT,
        WRITE_SHIFT,
        WRITE_COMMIT,
        DONE
    } state_t;

    // Value of the counter while the last edge pulse of a phase is being
    // consumed. width is at most 15, so the 4-bit counter never wraps.
    localparam logic [3:0] LAST_BIT = 4'(width - 1);

    state_t     state_q, state_d;
    logic [3:0] bit_count_q, bit_count_d;

    // Only the rw bit of the header steers the FSM. The address bits go
    // straight from the shift register to the address latch.
    logic unused_hdr_bits;
    assign unused_hdr_bits = ^shiftRegOut[width-1:1];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_count_q <= bit_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_count_d = bit_count_q;

        unique case (state_q)
            IDLE: begin
                if (!csN) state_d = GET_HDR;
            end
            GET_HDR: begin
                if (sclkPosEdge) begin
                    if (bit_count_q == LAST_BIT) state_d = GOT_HDR;
                    else bit_count_d = bit_count_q + 4'd1;
                end
            end
            GOT_HDR: begin
                state_d = shiftRegOut[0] ? READ_LOAD : WRITE_SHIFT;
            end
            READ_LOAD: begin
                // The shift register takes the parallel load on its next
                // clock pulse. parallelLoad is held until that pulse arrives.
                if (sclkPosEdge) state_d = READ_SHIFT;
            end
            READ_SHIFT: begin
                if (sclkNegEdge) begin
                    if (bit_count_q == LAST_BIT) state_d = DONE;
                    else bit_count_d = bit_count_q + 4'd1;
                end
            end
            WRITE_SHIFT: begin
                if (sclkPosEdge) begin
                    if (bit_count_q == LAST_BIT) state_d = WRITE_COMMIT;
                    else bit_count_d = bit_count_q + 4'd1;
                end
            end
            WRITE_COMMIT: begin
                state_d = DONE;
            end
            DONE: begin
                if (csN) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Deselect aborts any frame. This overrides an edge pulse that arrives
        // in the same clk, so a truncated write never reaches WRITE_COMMIT.
        if (csN && state_q != IDLE) state_d = IDLE;

        // Every phase starts counting from zero.
        if (state_d != state_q) bit_count_d = '0;
    end

    // Moore outputs. Reset forces IDLE, which clears all outputs at once.
    assign addrWE       = (state_q == GOT_HDR);
    assign parallelLoad = (state_q == READ_LOAD);
    assign misoBufE     = (state_q == READ_SHIFT);
    assign dmWE         = (state_q == WRITE_COMMIT);

endmodule

// File: tb/tb_spi_transaction_fsm.sv
module tb_spi_transaction_fsm;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         resetN = 1'b0;
    logic         csN = 1'b1;
    logic         sclkPosEdge = 1'b0;
    logic         sclkNegEdge = 1'b0;
    logic [W-1:0] shiftRegOut = '0;
    logic         addrWE, dmWE, parallelLoad, misoBufE;

    int tests_run = 0;
    int tests_failed = 0;

    // Output activity counters, sampled mid-cycle.
    int n_addr = 0, n_dm = 0, n_pl = 0, n_miso = 0, n_miso_neg = 0;

    spi_transaction_fsm #(.width(W)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .csN         (csN),
        .sclkPosEdge (sclkPosEdge),
        .sclkNegEdge (sclkNegEdge),
        .shiftRegOut (shiftRegOut),
        .addrWE      (addrWE),
        .dmWE        (dmWE),
        .parallelLoad(parallelLoad),
        .misoBufE    (misoBufE)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (addrWE)       n_addr++;
        if (dmWE)         n_dm++;
        if (parallelLoad) n_pl++;
        if (misoBufE)     n_miso++;
        if (misoBufE && sclkNegEdge) n_miso_neg++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_addrWE"}, addrWE, 1'b0);
        chk({tag, "_dmWE"}, dmWE, 1'b0);
        chk({tag, "_pl"}, parallelLoad, 1'b0);
        chk({tag, "_miso"}, misoBufE, 1'b0);
    endtask

    // Called one clk after csN falls (FSM in GET_HDR). Leaves the FSM in GOT_HDR.
    task automatic send_header(input logic [W-1:0] hdr);
        shiftRegOut = hdr;
        for (int i = 0; i < W; i++) begin
            sclkPosEdge = 1'b1;
            tick();
            sclkPosEdge = 1'b0;
            if (i < W - 1) begin
                chk("hdr_early_addrWE", addrWE, 1'b0);
                tick();
            end
        end
        chk("hdr_addrWE_after_last_edge", addrWE, 1'b1);
        chk("hdr_no_pl_in_got_hdr", parallelLoad, 1'b0);
    endtask

    // Called in WRITE_SHIFT. With n == W the FSM ends in WRITE_COMMIT.
    task automatic write_data(input int n);
        for (int i = 0; i < n; i++) begin
            sclkPosEdge = 1'b1;
            tick();
            sclkPosEdge = 1'b0;
            chk("wr_dmWE", dmWE, (i == W - 1) ? 1'b1 : 1'b0);
            if (i < n - 1) tick();
        end
    endtask

    task automatic full_write(input logic [W-1:0] hdr, input string tag);
        int a0, d0, p0, m0;
        a0 = n_addr; d0 = n_dm; p0 = n_pl; m0 = n_miso;
        csN = 1'b0;
        tick();
        send_header(hdr);
        tick();
        chk({tag, "_wshift_addrWE"}, addrWE, 1'b0);
        write_data(W);
        tick();
        chk({tag, "_done_dmWE"}, dmWE, 1'b0);
        csN = 1'b1;
        tick();
        chk_idle_outputs({tag, "_end"});
        chk_int({tag, "_addrWE_cycles"}, n_addr - a0, 1);
        chk_int({tag, "_dmWE_cycles"}, n_dm - d0, 1);
        chk_int({tag, "_pl_cycles"}, n_pl - p0, 0);
        chk_int({tag, "_miso_cycles"}, n_miso - m0, 0);
    endtask

    initial begin
        int a0, d0, p0, mn0;

        // Reset state
        #1;
        chk_idle_outputs("reset");
        tick();
        tick();
        resetN = 1'b1;
        tick();
        chk_idle_outputs("after_reset");

        // Write frame, header 0x54
        full_write(8'h54, "write");
        $display("[TB] write frame 0x54 done");

        // Read frame, header 0x55
        a0 = n_addr; p0 = n_pl; mn0 = n_miso_neg; d0 = n_dm;
        csN = 1'b0;
        tick();
        send_header(8'h55);
        tick();
        chk("rd_load_pl", parallelLoad, 1'b1);
        chk("rd_load_miso", misoBufE, 1'b0);
        tick();
        chk("rd_load_pl_held1", parallelLoad, 1'b1);
        tick();
        chk("rd_load_pl_held2", parallelLoad, 1'b1);
        sclkPosEdge = 1'b1;
        #1;
        chk("rd_load_pl_on_edge_clk", parallelLoad, 1'b1);
        tick();
        sclkPosEdge = 1'b0;
        chk("rd_shift_pl", parallelLoad, 1'b0);
        chk("rd_shift_miso", misoBufE, 1'b1);
        chk_int("rd_pl_cycles", n_pl - p0, 3);
        for (int i = 0; i < W; i++) begin
            sclkNegEdge = 1'b1;
            tick();
            sclkNegEdge = 1'b0;
            chk("rd_miso", misoBufE, (i == W - 1) ? 1'b0 : 1'b1);
            if (i < W - 1) begin
                // Rising edges are ignored while shifting out.
                sclkPosEdge = 1'b1;
                tick();
                sclkPosEdge = 1'b0;
                chk("rd_ignore_pos", misoBufE, 1'b1);
            end
        end
        // Stray pulses in DONE
        sclkPosEdge = 1'b1;
        sclkNegEdge = 1'b1;
        tick();
        tick();
        sclkPosEdge = 1'b0;
        sclkNegEdge = 1'b0;
        chk_idle_outputs("done_noise");
        csN = 1'b1;
        tick();
        chk_int("rd_miso_negedges", n_miso_neg - mn0, W);
        chk_int("rd_addrWE_cycles", n_addr - a0, 1);
        chk_int("rd_dmWE_cycles", n_dm - d0, 0);
        $display("[TB] read frame 0x55 done");

        // Abort after 5 write data edges
        d0 = n_dm;
        csN = 1'b0;
        tick();
        send_header(8'h54);
        tick();
        write_data(5);
        csN = 1'b1;
        tick();
        chk_idle_outputs("abort");
        tick();
        tick();
        chk_int("abort_dmWE_cycles", n_dm - d0, 0);
        full_write(8'h54, "after_abort");
        $display("[TB] abort frame done");

        // Race: csN rises with the last write-data edge
        d0 = n_dm;
        csN = 1'b0;
        tick();
        send_header(8'h54);
        tick();
        write_data(W - 1);
        tick();
        sclkPosEdge = 1'b1;
        csN = 1'b1;
        tick();
        sclkPosEdge = 1'b0;
        chk("race_dmWE", dmWE, 1'b0);
        tick();
        tick();
        chk_int("race_dmWE_cycles", n_dm - d0, 0);
        $display("[TB] race frame done");

        // Noise while deselected: pulses must not advance the header count
        a0 = n_addr;
        for (int i = 0; i < 5; i++) begin
            sclkPosEdge = 1'b1;
            sclkNegEdge = (i % 2 == 0);
            tick();
            sclkPosEdge = 1'b0;
            sclkNegEdge = 1'b0;
            chk_idle_outputs("idle_noise");
        end
        chk_int("idle_noise_addrWE", n_addr - a0, 0);
        full_write(8'h54, "after_noise");
        $display("[TB] noise check done");

        // Reset mid-READ_SHIFT
        csN = 1'b0;
        tick();
        send_header(8'h55);
        tick();
        sclkPosEdge = 1'b1;
        tick();
        sclkPosEdge = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sclkNegEdge = 1'b1;
            tick();
            sclkNegEdge = 1'b0;
        end
        chk("pre_reset_miso", misoBufE, 1'b1);
        #2;
        resetN = 1'b0;
        #1;
        chk_idle_outputs("async_reset");
        csN = 1'b1;
        tick();
        tick();
        resetN = 1'b1;
        tick();
        chk_idle_outputs("post_reset");
        full_write(8'h54, "post_reset_frame");
        $display("[TB] mid-frame reset done");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
